ikaopll_dac_dcblock: RTL

- Post-processor directly downstream of the accumulation DAC.
- Captures each strobed 16-bit signed accumulated sample and removes DC with a first-order high-pass filter (one-pole DC blocker), then saturates the result.
- Buffers results in a small FIFO with a valid/ready handshake toward the system audio mixer.
- Runs on the emulator master clock with no clock enables.

---
 rtl/ikaopll_dac_dcblock.sv | 110 +++++++++++
 1 files changed

// File: rtl/ikaopll_dac_dcblock.sv
// ikaopll_dac_dcblock: one-pole DC blocker with output clamp and FWFT output FIFO.
// Optional raw-capture bypass port enabled by defining IKAOPLL_DCBLOCK_BYPASS_EN.
module ikaopll_dac_dcblock #(
    parameter int K          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_EMUCLK,
    input  logic               i_RST,
    input  logic signed [15:0] i_ACC_SIGNED,
    input  logic               i_ACC_STRB,
    output logic signed [15:0] o_SAMPLE,
    output logic               o_VALID,
    input  logic               i_READY,
`ifdef IKAOPLL_DCBLOCK_BYPASS_EN
    input  logic               i_BYPASS,
`endif
    output logic               o_OVF,
    output logic               o_MISS
);
    localparam int W  = 19 + K;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [W-K-1:0] Y_MAX = (W-K)'(32767);
    localparam logic signed [W-K-1:0] Y_MIN = -(W-K)'(32768);

    typedef enum logic [1:0] {IDLE, FILTER, SAT, PUSH} state_t;

    state_t              state_q, state_d;
    logic                strb_z_q;
    logic signed [15:0]  x_q, x_d, x1_q, x1_d, ysat_q, ysat_d, last_q, last_d;
    logic signed [W-1:0] yf_q, yf_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                ovf_q, ovf_d, miss_q, miss_d;
    logic signed [15:0]  mem_q [FIFO_DEPTH];
    logic                rise, full, push, pop, bypass;
    logic signed [16:0]  diff;
    logic signed [W-K-1:0] y;

`ifdef IKAOPLL_DCBLOCK_BYPASS_EN
    assign bypass = i_BYPASS;
`else
    assign bypass = 1'b0;
`endif

    assign o_VALID  = count_q != '0;
    assign o_SAMPLE = o_VALID ? mem_q[rd_ptr_q] : last_q;
    assign o_OVF    = ovf_q;
    assign o_MISS   = miss_q;

    always_comb begin
        rise     = i_ACC_STRB & ~strb_z_q;
        full     = count_q == (AW+1)'(FIFO_DEPTH);
        pop      = o_VALID & i_READY;
        push     = (state_q == PUSH) & (~full | pop);
        diff     = {x_q[15], x_q} - {x1_q[15], x1_q};
        y        = (W-K)'(yf_q >>> K);
        state_d  = state_q == IDLE   ? (rise ? FILTER : IDLE) :
                   state_q == FILTER ? SAT :
                   state_q == SAT    ? PUSH : IDLE;
        x_d      = (state_q == IDLE && rise) ? i_ACC_SIGNED : x_q;
        x1_d     = state_q == FILTER ? x_q : x1_q;
        // yf carries y scaled by 2^K so the pole subtraction keeps fractional precision
        yf_d     = state_q == FILTER ? yf_q - (yf_q >>> K) + (W'(diff) <<< K) : yf_q;
        ysat_d   = state_q != SAT ? ysat_q :
                   bypass         ? x_q :
                   y > Y_MAX      ? 16'sh7fff :
                   y < Y_MIN      ? 16'sh8000 : y[15:0];
        miss_d   = miss_q | (rise & (state_q != IDLE));
        ovf_d    = ovf_q | ((state_q == PUSH) & ~push);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge i_EMUCLK) begin
        // tracks the strobe through reset so a level already high is not a rise
        strb_z_q <= i_ACC_STRB;
        if (i_RST) begin
            state_q  <= IDLE;
            x_q      <= '0;
            x1_q     <= '0;
            yf_q     <= '0;
            ysat_q   <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            x1_q     <= x1_d;
            yf_q     <= yf_d;
            ysat_q   <= ysat_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            miss_q   <= miss_d;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (push && !i_RST)
            mem_q[wr_ptr_q] <= ysat_q;
    end
endmodule
